// File: rtl/kanagawa_fifo_write_arbiter.sv
// Round-robin write arbiter feeding one register FIFO; the grant is combinational from req_valid.
// Define KANAGAWA_ARB_BURST_EN to let a port keep the grant for up to MAX_BURST consecutive transfers.
module kanagawa_fifo_write_arbiter #(
   parameter int WIDTH     = 32,
   parameter int PORTS     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                       clock,
   input  logic                       rst,
   input  logic [PORTS-1:0]           req_valid,
   input  logic [PORTS*WIDTH-1:0]     req_data,
   output logic [PORTS-1:0]           req_ready,
   output logic                       fifo_wrreq,
   output logic [WIDTH-1:0]           fifo_data,
   input  logic                       fifo_full,
   output logic [$clog2(PORTS)-1:0]   grant_idx
);

   localparam int IDX_W = $clog2(PORTS);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] grant;
   logic             found;
   logic [IDX_W:0]   sum;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(PORTS-1)) ? '0 : i + 1'b1;
   endfunction

   // First valid port at or after ptr, wrapping. In a burst this also covers the
   // "owner dropped valid" case: ptr itself is skipped and the search continues at ptr+1.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
      grant = '0;
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < PORTS; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(PORTS)) sum = sum - (IDX_W+1)'(PORTS);
         if (!found && req_valid[sum[IDX_W-1:0]]) begin
            grant = sum[IDX_W-1:0];
            found = 1'b1;
         end
      end
   end

   assign fifo_wrreq = (|req_valid) & ~fifo_full & ~rst;
   assign req_ready  = fifo_wrreq ? (PORTS'(1) << grant) : '0;
   assign grant_idx  = fifo_wrreq ? grant : '0;

   always_comb begin
      fifo_data = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (grant == IDX_W'(p)) fifo_data = req_data[p*WIDTH +: WIDTH];
      end
   end

`ifdef KANAGAWA_ARB_BURST_EN
   localparam int CNT_W = $clog2(MAX_BURST+1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;

   // A stalled FIFO freezes ptr, count and state; the grant is still re-evaluated each cycle.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         ptr   <= '0;
         count <= '0;
         state <= IDLE;
      end else if (!fifo_full) begin
         case (state)
            IDLE: begin
               if (fifo_wrreq) begin
                  if (MAX_BURST > 1) begin
                     ptr   <= grant;
                     count <= CNT_W'(1);
                     state <= BURST;
                  end else begin
                     ptr <= wrap_inc(grant);
                  end
               end
            end
            BURST: begin
               if (req_valid[ptr]) begin
                  if (count + 1'b1 == CNT_W'(MAX_BURST)) begin
                     ptr   <= wrap_inc(ptr);
                     count <= '0;
                     state <= IDLE;
                  end else begin
                     count <= count + 1'b1;
                  end
               end else begin
                  ptr   <= wrap_inc(ptr);
                  count <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clock) begin
      if (rst) begin
         ptr <= '0;
      end else if (fifo_wrreq) begin
         ptr <= wrap_inc(grant);
      end
   end
`endif

endmodule
